// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the AXI line-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_START,
        WB_WAIT,
        RD_START,
        RD_WAIT
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam int DEF_LINE_OFFSET = 6;
    localparam int DEF_TIMEOUT     = 1024;

endpackage

// File: rtl/timeout_counter.sv
// Wait-state cycle counter; o_expired flags the last permitted wait cycle.
module timeout_counter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic arstn,
    input  logic clr,
    input  logic en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_expired = en && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the AXI line port for I-cache refills and D-cache writeback/refill.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int LINE_OFFSET = DEF_LINE_OFFSET,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_instr_req,
    input  logic [ADDR_WIDTH-1:0] i_instr_addr,
    input  logic                  i_data_req,
    input  logic                  i_data_dirty,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [ADDR_WIDTH-1:0] i_data_wb_addr,
    input  logic                  i_read_last_axi,
    input  logic                  i_b_resp_axi,
    output logic                  o_start_read_axi,
    output logic                  o_start_write_axi,
    output logic [ADDR_WIDTH-1:0] o_addr_axi,
    output logic                  o_instr_fill_we,
    output logic                  o_data_fill_we,
    output logic                  o_instr_done,
    output logic                  o_data_done,
    output logic                  o_err,
    output logic                  o_grant_data,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFFSET) - ADDR_WIDTH'(1));

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return a & LINE_MASK;
    endfunction

    arb_state_t            state, state_nxt;
    grant_t                grant, last_grant, pick;
    logic                  take;
    logic [ADDR_WIDTH-1:0] fill_addr, wb_addr;
    logic                  cnt_clr, cnt_en, expired;
    logic                  done, fill;

    // Data wins a tie only when instr held the port last.
    always_comb begin
        take = i_instr_req | i_data_req;
        pick = (i_data_req && (!i_instr_req || last_grant == INSTR)) ? DATA : INSTR;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= IDLE;
            grant      <= INSTR;
            last_grant <= INSTR;
        end else begin
            state <= state_nxt;
            if (state == IDLE && take) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    // Address latches carry no reset; o_addr_axi is forced to 0 in IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && take) begin
            fill_addr <= line_align((pick == DATA) ? i_data_addr : i_instr_addr);
            wb_addr   <= line_align(i_data_wb_addr);
        end
    end

    timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .arstn     (arstn),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .o_expired (expired)
    );

    always_comb begin
        state_nxt         = state;
        o_start_read_axi  = 1'b0;
        o_start_write_axi = 1'b0;
        o_addr_axi        = '0;
        o_err             = 1'b0;
        done              = 1'b0;
        fill              = 1'b0;
        cnt_clr           = 1'b0;
        cnt_en            = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (take) begin
                    state_nxt = (pick == DATA && i_data_dirty) ? WB_START : RD_START;
                end
            end
            WB_START: begin
                o_start_write_axi = 1'b1;
                o_addr_axi        = wb_addr;
                cnt_clr           = 1'b1;
                state_nxt         = WB_WAIT;
            end
            WB_WAIT: begin
                o_addr_axi = wb_addr;
                cnt_en     = 1'b1;
                if (i_b_resp_axi) begin
                    state_nxt = RD_START;
                end else if (expired) begin
                    done      = 1'b1;
                    o_err     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_START: begin
                o_start_read_axi = 1'b1;
                o_addr_axi       = fill_addr;
                cnt_clr          = 1'b1;
                state_nxt        = RD_WAIT;
            end
            RD_WAIT: begin
                o_addr_axi = fill_addr;
                cnt_en     = 1'b1;
                if (i_read_last_axi) begin
                    done      = 1'b1;
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end else if (expired) begin
                    done      = 1'b1;
                    o_err     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_instr_fill_we = fill && (grant == INSTR);
    assign o_data_fill_we  = fill && (grant == DATA);
    assign o_instr_done    = done && (grant == INSTR);
    assign o_data_done     = done && (grant == DATA);
    assign o_grant_data    = (state != IDLE) && (grant == DATA);
    assign o_busy          = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single AXI line-transfer port between instruction-cache refills and data-cache refills/writebacks. Sits between `instr_cache`/`data_cache` plus `control_unit` and the external AXI adapter. It owns `o_start_read_axi`, `o_start_write_axi` and the line address. It sequences dirty-victim writeback before refill and aborts transfers that never complete.

## Interface
- `ADDR_WIDTH`, 64, byte address width.
- `LINE_OFFSET`, 6, low address bits forced to zero (512-bit line).
- `TIMEOUT`, 1024, maximum cycles spent in a wait state before abort.
- `clk` in 1: single clock, rising edge.
- `arstn` in 1: reset, asynchronous, active-low.
- `i_instr_req` in 1: I-cache line fill request; level, held until `o_instr_done`.
- `i_instr_addr` in ADDR_WIDTH: I-cache fill address.
- `i_data_req` in 1: D-cache miss request; level, held until `o_data_done`.
- `i_data_dirty` in 1: victim is dirty, so a writeback precedes the refill.
- `i_data_addr` in ADDR_WIDTH: D-cache fill address.
- `i_data_wb_addr` in ADDR_WIDTH: victim writeback address.
- `i_read_last_axi` in 1: last beat of line read received.
- `i_b_resp_axi` in 1: write response received.
- `o_start_read_axi` out 1: one-cycle pulse that starts a line read.
- `o_start_write_axi` out 1: one-cycle pulse that starts a line write.
- `o_addr_axi` out ADDR_WIDTH: line-aligned transfer address.
- `o_instr_fill_we` out 1: pulse that writes the AXI read line into the I-cache.
- `o_data_fill_we` out 1: pulse that writes the AXI read line into the D-cache.
- `o_instr_done` out 1: pulse when the I request has completed.
- `o_data_done` out 1: pulse when the D request has completed.
- `o_err` out 1: pulse with done when a transaction timed out.
- `o_grant_data` out 1: 1 while the D request owns the port.
- `o_busy` out 1: 1 in any state other than IDLE.

## Operation
- States: IDLE, WB_START, WB_WAIT, RD_START, RD_WAIT.
- IDLE, no request pending: stay in IDLE.
- IDLE, exactly one request pending: grant it.
- IDLE, both requests pending: round-robin via `last_grant`. Grant the requester not granted last. Reset value of `last_grant` is instr, so data wins the first tie.
- At grant, latch the grant (`o_grant_data`) and both addresses, masking the low LINE_OFFSET bits to zero. Update `last_grant`.
- Data grant with `i_data_dirty`=1: next state WB_START. Any other grant: next state RD_START.
- WB_START: `o_start_write_axi`=1 for exactly one cycle, then WB_WAIT.
- WB_WAIT, `i_b_resp_axi`=1: go to RD_START.
- RD_START: `o_start_read_axi`=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT, `i_read_last_axi`=1, same cycle: pulse the granted fill_we and the granted done, then return to IDLE.
- `o_addr_axi` holds the writeback address from WB_START through WB_WAIT. It holds the fill address from RD_START through RD_WAIT. It is 0 in IDLE.
- Timeout: the counter clears on entering either wait state and increments each wait cycle.
  - At count TIMEOUT-1 with no response: pulse granted done and `o_err`, with no fill_we.
  - Then return to IDLE. A writeback timeout skips the refill.
- Inputs are sampled only in the state where they are meaningful:
  - `i_read_last_axi` is ignored outside RD_WAIT.
  - `i_b_resp_axi` is ignored outside WB_WAIT.
  - Request and address changes after grant are ignored.

## Timing
- Reset value of every output is 0. Reset state is IDLE, counter is 0, `last_grant` is instr.
- Reset asserted mid-transaction: return to IDLE immediately, with no done, fill_we or err pulse.
- Grant to start pulse: 1 cycle. From IDLE with request visible in cycle N, the start pulse is in cycle N+1.
- Done is combinational with `i_read_last_axi` in RD_WAIT.
- A requester deasserts req on the edge at which it samples done=1. The arbiter is in IDLE the cycle after done, so there is one idle cycle minimum between transactions.
- Response and timeout in the same cycle: the response wins, and no `o_err` is raised.
- Dirty data miss, minimum: 1 (WB_START) + ≥1 (WB_WAIT) + 1 (RD_START) + ≥1 (RD_WAIT) cycles after grant.

## Structure
- Package `mem_arbiter_pkg`:
  - `arb_state_t` enum for the five states.
  - `grant_t` (INSTR/DATA).
  - Default LINE_OFFSET and TIMEOUT constants.
- Sub-module `timeout_counter`: parameter TIMEOUT; ports `clr` and `en`; output `o_expired`. Width is $clog2(TIMEOUT). Asynchronous active-low reset.
- FSM and grant/address latches are in `mem_arbiter`.

## Test plan
- I request only, addr 0x1234, `i_read_last_axi` 5 cycles after start:
  - Expect `o_start_read_axi` one cycle after req.
  - Expect `o_addr_axi`=0x1200.
  - Expect `o_instr_fill_we` and `o_instr_done` in the read_last cycle.
- Both requests in the same cycle after reset:
  - First grant goes to data.
  - After data done, I is granted one IDLE cycle later.
  - With both held again, grants alternate.
- Dirty D miss, wb addr 0x8040, fill addr 0x40A8:
  - Expect a write start at 0x8040.
  - `b_resp` at 3 cycles, then a read start at 0x4080 in the next cycle.
  - Then `o_data_fill_we` and `o_data_done`.
- TIMEOUT=16, no `read_last`:
  - Expect `o_data_done` and `o_err` in the 16th RD_WAIT cycle.
  - Expect no fill_we, then IDLE.
- `i_read_last_axi` and `i_b_resp_axi` pulsed in IDLE/START states: no state change and no outputs.
  - Then `arstn` low in RD_WAIT: all outputs 0, IDLE, and no done on release.
